// File: rtl/dqsdll_update_ctrl_pkg.sv
// Shared types and constants for the DQSDLLC sequencing controller:
// FSM state encoding, default timing constants and counter sizing.
package dqsdll_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RST_HOLD  = 3'd1,
    WAIT_LOCK = 3'd2,
    UPDATE    = 3'd3,
    TRACK     = 3'd4,
    FAIL      = 3'd5
  } dll_state_e;

  localparam int DEF_RST_CYC      = 8;
  localparam int DEF_LOCK_TIMEOUT = 1024;
  localparam int DEF_MAX_RETRY    = 3;
  localparam int DEF_UPD_CYC      = 4;
  localparam int DEF_UPD_INTERVAL = 65536;

  // One bit beyond $clog2 so a counter can hold its terminal value and saturate.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dqsdll_update_ctrl_if.sv
// Signal bundle between the PHY bring-up / memory controller side, the
// DQSDLLC primitive and the update controller. The controller uses the
// slave view; whoever drives requests and LOCK uses the master view.
interface dqsdll_update_ctrl_if;

  logic START;
  logic UPD_REQ;
  logic UPD_ACK;
  logic FREEZE_REQ;
  logic READY;
  logic ERR;
  logic DLL_LOCK;
  logic DLL_RST;
  logic DLL_UDDCNTLN;
  logic DLL_FREEZE;

  modport master (
    output START,
    output UPD_REQ,
    output FREEZE_REQ,
    output DLL_LOCK,
    input  UPD_ACK,
    input  READY,
    input  ERR,
    input  DLL_RST,
    input  DLL_UDDCNTLN,
    input  DLL_FREEZE
  );

  modport slave (
    input  START,
    input  UPD_REQ,
    input  FREEZE_REQ,
    input  DLL_LOCK,
    output UPD_ACK,
    output READY,
    output ERR,
    output DLL_RST,
    output DLL_UDDCNTLN,
    output DLL_FREEZE
  );

endinterface

// File: rtl/dqsdll_lock_sync.sv
// Two-flop synchronizer for the DQSDLLC LOCK output plus a registered
// fall detect that pulses in the same cycle lock_s first reads low.
module dqsdll_lock_sync (
  input  logic CLK,
  input  logic RST,
  input  logic lock_in,
  output logic lock_s,
  output logic lock_fall
);

  logic lock_p0;

  // Synchronize LOCK and flag the 1->0 transition of the synchronized value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_p0   <= 1'b0;
      lock_s    <= 1'b0;
      lock_fall <= 1'b0;
    end else begin
      lock_p0   <= lock_in;
      lock_s    <= lock_p0;
      lock_fall <= lock_s & ~lock_p0;
    end
  end

endmodule

// File: rtl/dqsdll_update_ctrl.sv
// Sequencing controller for one DQSDLLC: reset/bring-up with lock timeout
// and retry, delay-code update arbitration and freeze gating.
// Optional periodic update timer: define DQSDLL_CTRL_AUTO_UPDATE_EN.
module dqsdll_update_ctrl
  import dqsdll_ctrl_pkg::*;
#(
  parameter int RST_CYC      = DEF_RST_CYC,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int MAX_RETRY    = DEF_MAX_RETRY,
  parameter int UPD_CYC      = DEF_UPD_CYC,
  parameter int UPD_INTERVAL = DEF_UPD_INTERVAL
) (
  input logic                 CLK,
  input logic                 RST,
  dqsdll_update_ctrl_if.slave bus
);

  // One phase counter is shared by RST_HOLD, WAIT_LOCK and UPDATE; it
  // restarts from zero on every state change.
  localparam int PH_W = cnt_w(max3(RST_CYC, LOCK_TIMEOUT, UPD_CYC));
  localparam int RT_W = cnt_w(MAX_RETRY);

  localparam logic [PH_W-1:0] RST_LAST  = PH_W'(RST_CYC - 1);
  localparam logic [PH_W-1:0] LOCK_LAST = PH_W'(LOCK_TIMEOUT - 1);
  localparam logic [PH_W-1:0] UPD_LAST  = PH_W'(UPD_CYC - 1);
  localparam logic [RT_W-1:0] RT_MAX    = RT_W'(MAX_RETRY);

  dll_state_e      state, state_nxt;
  logic [PH_W-1:0] ph_cnt;
  logic [RT_W-1:0] retry_cnt;
  logic            retry_clr;
  logic            retry_inc;
  logic            for_req, for_req_nxt;
  logic            lock_s;
  logic            lock_fall;
  logic            auto_pend;
  logic            upd_entry;

  logic            dll_rst_q;
  logic            udd_n_q;
  logic            frz_q;
  logic            ready_q;
  logic            err_q;
  logic            ack_q;

  dqsdll_lock_sync u_lock_sync (
    .CLK       (CLK),
    .RST       (RST),
    .lock_in   (bus.DLL_LOCK),
    .lock_s    (lock_s),
    .lock_fall (lock_fall)
  );

  assign upd_entry = (state_nxt == UPDATE) && (state != UPDATE);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      for_req <= 1'b0;
    end else begin
      state   <= state_nxt;
      for_req <= for_req_nxt;
    end
  end

  // Next-state logic and retry bookkeeping strobes.
  always_comb begin
    state_nxt   = state;
    for_req_nxt = for_req;
    retry_clr   = 1'b0;
    retry_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.START) begin
          state_nxt = RST_HOLD;
          retry_clr = 1'b1;
        end
      end
      RST_HOLD: begin
        if (ph_cnt == RST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock wins over a timeout landing in the same cycle.
        if (lock_s) begin
          state_nxt   = UPDATE;
          for_req_nxt = 1'b0;
        end else if (ph_cnt == LOCK_LAST) begin
          if (retry_cnt < RT_MAX) begin
            state_nxt = RST_HOLD;
            retry_inc = 1'b1;
          end else begin
            state_nxt = FAIL;
          end
        end
      end
      UPDATE: begin
        if (ph_cnt == UPD_LAST) state_nxt = TRACK;
      end
      TRACK: begin
        // The ack cycle masks UPD_REQ: the requester can only drop it after
        // seeing the ack, so the still-high level must not restart an update.
        if (!lock_s || lock_fall) begin
          state_nxt = RST_HOLD;
          retry_clr = 1'b1;
        end else if (bus.UPD_REQ && !ack_q && !bus.FREEZE_REQ) begin
          state_nxt   = UPDATE;
          for_req_nxt = 1'b1;
        end else if (auto_pend && !bus.FREEZE_REQ) begin
          state_nxt   = UPDATE;
          for_req_nxt = 1'b0;
        end
      end
      FAIL: begin
        if (bus.START) begin
          state_nxt = RST_HOLD;
          retry_clr = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Phase counter: zero on every state change, otherwise saturating count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ph_cnt <= '0;
    end else if (state_nxt != state) begin
      ph_cnt <= '0;
    end else if (ph_cnt != '1) begin
      ph_cnt <= ph_cnt + PH_W'(1);
    end
  end

  // Retry counter: cleared on a fresh bring-up, bumped on each timed-out attempt.
  always_ff @(posedge CLK) begin
    if (RST) begin
      retry_cnt <= '0;
    end else if (retry_clr) begin
      retry_cnt <= '0;
    end else if (retry_inc && (retry_cnt != '1)) begin
      retry_cnt <= retry_cnt + RT_W'(1);
    end
  end

`ifdef DQSDLL_CTRL_AUTO_UPDATE_EN
  localparam int              TM_W    = cnt_w(UPD_INTERVAL);
  localparam logic [TM_W-1:0] TM_LAST = TM_W'(UPD_INTERVAL - 1);

  logic [TM_W-1:0] tmr_cnt;

  // Interval timer runs only in TRACK; expiry latches a pending request
  // that survives FREEZE_REQ until an update actually starts.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tmr_cnt   <= '0;
      auto_pend <= 1'b0;
    end else if (upd_entry) begin
      tmr_cnt   <= '0;
      auto_pend <= 1'b0;
    end else if (state == TRACK) begin
      if (tmr_cnt == TM_LAST) begin
        auto_pend <= 1'b1;
      end else begin
        tmr_cnt <= tmr_cnt + TM_W'(1);
      end
    end
  end
`else
  // Without the timer, updates come only from UPD_REQ and UPD_INTERVAL has
  // no consumer.
  logic unused_upd_interval;
  logic unused_upd_entry;
  assign auto_pend           = 1'b0;
  assign unused_upd_interval = ^UPD_INTERVAL;
  assign unused_upd_entry    = upd_entry;
`endif

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dll_rst_q <= 1'b1;
      udd_n_q   <= 1'b1;
      frz_q     <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      dll_rst_q <= (state_nxt == IDLE) || (state_nxt == RST_HOLD) ||
                   (state_nxt == FAIL);
      udd_n_q   <= (state_nxt != UPDATE);
      frz_q     <= (state_nxt == TRACK) && bus.FREEZE_REQ;
      ready_q   <= (state_nxt == TRACK);
      err_q     <= (state_nxt == FAIL);
      ack_q     <= (state == UPDATE) && (state_nxt == TRACK) && for_req;
    end
  end

  assign bus.DLL_RST      = dll_rst_q;
  assign bus.DLL_UDDCNTLN = udd_n_q;
  assign bus.DLL_FREEZE   = frz_q;
  assign bus.READY        = ready_q;
  assign bus.ERR          = err_q;
  assign bus.UPD_ACK      = ack_q;

endmodule
